// File: rtl/vprobe_period_meter.sv
// rtl/vprobe_period_meter.sv - rising-zero-crossing period, peak and trough meter for a signed sample stream
//
// Purpose:
//   Classifies each accepted sample as LOW (<= -HYST), HIGH (>= +HYST) or mid-band.
//   A HIGH sample that follows a LOW sample is a rising event. Between two rising events
//   the block counts samples and tracks the signed max/min, then reports them as one result.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_valid    in   sample present
//   s_data     in   signed sample, DW bits
//   s_ready    out  sample accepted when s_valid && s_ready
//   m_valid    out  result available
//   m_ready    in   result consumed when m_valid && m_ready
//   m_period   out  samples per period, CW bits, saturating
//   m_peak     out  signed maximum over the period
//   m_trough   out  signed minimum over the period
//   m_overflow out  period counter saturated during this period
//   locked     out  at least one rising event seen since reset
module vprobe_period_meter #(
  parameter int DW   = 16,
  parameter int CW   = 24,
  parameter int HYST = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_period,
  output logic [DW-1:0] m_peak,
  output logic [DW-1:0] m_trough,
  output logic          m_overflow,
  output logic          locked
);

  typedef enum logic [1:0] {
    SEEK_LOW  = 2'd0,
    SEEK_RISE = 2'd1,
    MEAS_LOW  = 2'd2,
    MEAS_RISE = 2'd3
  } state_t;

  localparam logic signed [DW-1:0] HI_TH = DW'(HYST);
  localparam logic signed [DW-1:0] LO_TH = -HI_TH;
  localparam logic [CW-1:0]        CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic signed [DW-1:0]  pk_q, pk_d;
  logic signed [DW-1:0]  tr_q, tr_d;
  logic                  init_q, init_d;
  logic                  locked_q, locked_d;
  logic                  mv_q, mv_d;
  logic [CW-1:0]         per_q, per_d;
  logic signed [DW-1:0]  mpk_q, mpk_d;
  logic signed [DW-1:0]  mtr_q, mtr_d;
  logic                  movf_q, movf_d;

  logic                  accept;
  logic signed [DW-1:0]  sample;
  logic                  is_low;
  logic                  is_high;
  logic                  cnt_sat;
  logic signed [DW-1:0]  win_pk;
  logic signed [DW-1:0]  win_tr;

  // No sample buffering: a pending result blocks input unless it is being consumed now.
  assign s_ready = !mv_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign sample  = $signed(s_data);
  assign is_low  = (sample <= LO_TH);
  assign is_high = (sample >= HI_TH);
  assign cnt_sat = (cnt_q == CNT_MAX);

  // Running extremes including the current sample; the first sample of a window seeds both.
  assign win_pk = (!init_q || (sample > pk_q)) ? sample : pk_q;
  assign win_tr = (!init_q || (sample < tr_q)) ? sample : tr_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    pk_d     = pk_q;
    tr_d     = tr_q;
    init_d   = init_q;
    locked_d = locked_q;
    mv_d     = mv_q && !m_ready;
    per_d    = per_q;
    mpk_d    = mpk_q;
    mtr_d    = mtr_q;
    movf_d   = movf_q;

    if (accept) begin
      case (state_q)
        SEEK_LOW: begin
          if (is_low) state_d = SEEK_RISE;
        end
        SEEK_RISE: begin
          if (is_high) begin
            state_d  = MEAS_LOW;
            locked_d = 1'b1;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            init_d   = 1'b0;
          end
        end
        MEAS_LOW, MEAS_RISE: begin
          if ((state_q == MEAS_RISE) && is_high) begin
            // Rising event closes the window; the event sample is part of it.
            state_d = MEAS_LOW;
            mv_d    = 1'b1;
            per_d   = cnt_sat ? cnt_q : cnt_q + CW'(1);
            mpk_d   = win_pk;
            mtr_d   = win_tr;
            // A saturated count at emit also means the true period did not fit.
            movf_d  = ovf_q || cnt_sat;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            init_d  = 1'b0;
          end else begin
            cnt_d  = cnt_sat ? cnt_q : cnt_q + CW'(1);
            ovf_d  = ovf_q || cnt_sat;
            pk_d   = win_pk;
            tr_d   = win_tr;
            init_d = 1'b1;
            if ((state_q == MEAS_LOW) && is_low) state_d = MEAS_RISE;
          end
        end
        default: state_d = SEEK_LOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEEK_LOW;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pk_q     <= '0;
      tr_q     <= '0;
      init_q   <= 1'b0;
      locked_q <= 1'b0;
      mv_q     <= 1'b0;
      per_q    <= '0;
      mpk_q    <= '0;
      mtr_q    <= '0;
      movf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      pk_q     <= pk_d;
      tr_q     <= tr_d;
      init_q   <= init_d;
      locked_q <= locked_d;
      mv_q     <= mv_d;
      per_q    <= per_d;
      mpk_q    <= mpk_d;
      mtr_q    <= mtr_d;
      movf_q   <= movf_d;
    end
  end

  assign m_valid    = mv_q;
  assign m_period   = per_q;
  assign m_peak     = mpk_q;
  assign m_trough   = mtr_q;
  assign m_overflow = movf_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_vprobe_period_meter.sv
// tb/tb_vprobe_period_meter.sv - directed bench for vprobe_period_meter
module tb_vprobe_period_meter;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        m_ready;

  logic        s_ready;
  logic        m_valid;
  logic [23:0] m_period;
  logic [15:0] m_peak;
  logic [15:0] m_trough;
  logic        m_overflow;
  logic        locked;

  logic        o_s_ready;
  logic        o_m_valid;
  logic [3:0]  o_m_period;
  logic [15:0] o_m_peak;
  logic [15:0] o_m_trough;
  logic        o_m_overflow;
  logic        o_locked;

  int n_pass;
  int n_total;

  localparam logic [15:0] P100 = 16'h0064;
  localparam logic [15:0] N100 = 16'hFF9C;

  vprobe_period_meter #(.DW(16), .CW(24), .HYST(64)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_period   (m_period),
    .m_peak     (m_peak),
    .m_trough   (m_trough),
    .m_overflow (m_overflow),
    .locked     (locked)
  );

  vprobe_period_meter #(.DW(16), .CW(4), .HYST(64)) u_ovf (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (o_s_ready),
    .m_valid    (o_m_valid),
    .m_ready    (m_ready),
    .m_period   (o_m_period),
    .m_peak     (o_m_peak),
    .m_trough   (o_m_trough),
    .m_overflow (o_m_overflow),
    .locked     (o_locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] sq(input int i);
    return ((i % 10) < 5) ? N100 : P100;
  endfunction

  // 20-sample period, then a 10-sample period closing at index 40
  function automatic logic [15:0] ovf_seq(input int i);
    if (i >= 35 && i <= 39) return N100;
    if (i == 40) return P100;
    return (((i / 10) % 2) == 1) ? P100 : N100;
  endfunction

  task automatic step(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  32'(m_valid),    32'd0);
    check({tag, "_period"}, 32'(m_period),   32'd0);
    check({tag, "_peak"},   32'(m_peak),     32'd0);
    check({tag, "_trough"}, 32'(m_trough),   32'd0);
    check({tag, "_ovf"},    32'(m_overflow), 32'd0);
    check({tag, "_locked"}, 32'(locked),     32'd0);
    check({tag, "_sready"}, 32'(s_ready),    32'd1);
  endtask

  initial begin
    logic exp_v;
    logic seen_v;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;

    // Reset state before any clock edge
    #1;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Square wave, m_ready held high
    for (int i = 0; i < 40; i++) begin
      step(sq(i));
      exp_v = (i == 15) || (i == 25) || (i == 35);
      check("sq_valid", 32'(m_valid), 32'(exp_v));
      if (i == 5) check("sq_locked", 32'(locked), 32'd1);
      if (exp_v) begin
        check("sq_period", 32'(m_period),   32'd10);
        check("sq_peak",   32'(m_peak),     32'(P100));
        check("sq_trough", 32'(m_trough),   32'(N100));
        check("sq_ovf",    32'(m_overflow), 32'd0);
      end
    end
    check("sq_sready", 32'(s_ready), 32'd1);

    // Hysteresis reject
    do_reset();
    seen_v = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step((i % 2 == 0) ? 16'd50 : 16'hFFCE);
      if (m_valid) seen_v = 1'b1;
    end
    check("hys_valid_seen", 32'(seen_v), 32'd0);
    check("hys_locked",     32'(locked), 32'd0);

    // Backpressure after the first result
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) step(sq(i));
    check("bp_first_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = sq(16);
    #1;
    check("bp_sready_low", 32'(s_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid",  32'(m_valid),  32'd1);
      check("bp_hold_sready", 32'(s_ready),  32'd0);
      check("bp_hold_period", 32'(m_period), 32'd10);
      check("bp_hold_trough", 32'(m_trough), 32'(N100));
    end
    m_ready = 1'b1;
    #1;
    check("bp_sready_release", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp_after_hs_valid", 32'(m_valid), 32'd0);
    for (int i = 17; i < 26; i++) begin
      step(sq(i));
      check("bp_resume_valid", 32'(m_valid), 32'(i == 25));
    end
    check("bp_resume_period", 32'(m_period), 32'd10);
    check("bp_resume_peak",   32'(m_peak),   32'(P100));

    // Period counter overflow on the CW=4 instance
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      step(ovf_seq(i));
      check("ovf_sready", 32'(o_s_ready), 32'd1);
      check("ovf_valid",  32'(o_m_valid), 32'((i == 30) || (i == 40)));
      if (i == 30) begin
        check("ovf_long_period", 32'(o_m_period),   32'd15);
        check("ovf_long_flag",   32'(o_m_overflow), 32'd1);
        check("ovf_long_trough", 32'(o_m_trough),   32'(N100));
      end
      if (i == 40) begin
        check("ovf_short_period", 32'(o_m_period),   32'd10);
        check("ovf_short_flag",   32'(o_m_overflow), 32'd0);
        check("ovf_short_peak",   32'(o_m_peak),     32'(P100));
      end
    end
    check("ovf_locked", 32'(o_locked), 32'd1);

    // Asynchronous reset with a result pending, then replay
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) step(sq(i));
    m_ready = 1'b0;
    step(sq(15));
    check("mid_pending", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(sq(i));
      check("replay_valid", 32'(m_valid), 32'(i == 15));
    end
    check("replay_period", 32'(m_period), 32'd10);
    check("replay_ovf",    32'(m_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
